// File: rtl/hex_keypad_entry.sv
// Scans a 4x4 hex keypad, debounces whole-matrix frames and shifts accepted
// digits into a 16-bit entry value for the CPU control block.
module hex_keypad_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  input  logic        clear,
  input  logic        consume,
  output logic [15:0] user_input,
  output logic        input_valid,
  output logic [2:0]  digit_count,
  output logic        key_strobe,
  output logic [3:0]  key_code
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

  logic [3:0]       col_meta_q, col_meta_d;
  logic [3:0]       col_sync_q, col_sync_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       row_q, row_d;
  logic [15:0]      frame_q, frame_d;
  logic [15:0]      prev_frame_q, prev_frame_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [15:0]      acc_frame_q, acc_frame_d;
  logic [15:0]      user_input_q, user_input_d;
  logic [2:0]       digit_count_q, digit_count_d;
  logic             key_strobe_q, key_strobe_d;
  logic [3:0]       key_code_q, key_code_d;

  logic [3:0]  pressed;
  logic [15:0] full_frame;
  logic [15:0] new_bits;
  logic        frame_done;
  logic        one_hot;
  logic        digit_ok;
  logic [3:0]  digit_code;

  always_comb begin
    col_meta_d    = col_n;
    col_sync_d    = col_meta_q;
    scan_cnt_d    = scan_cnt_q + CNT_W'(1);
    row_d         = row_q;
    frame_d       = frame_q;
    prev_frame_d  = prev_frame_q;
    stable_d      = stable_q;
    acc_frame_d   = acc_frame_q;
    user_input_d  = user_input_q;
    digit_count_d = digit_count_q;
    key_strobe_d  = 1'b0;
    key_code_d    = key_code_q;
    frame_done    = 1'b0;
    one_hot       = 1'b0;
    digit_ok      = 1'b0;
    digit_code    = 4'd0;
    new_bits      = 16'd0;

    pressed    = ~col_sync_q;
    full_frame = {pressed, frame_q[11:0]};

    if (scan_cnt_q == CNT_LAST) begin
      scan_cnt_d                   = '0;
      row_d                        = row_q + 2'd1;
      frame_d[{row_q, 2'b00} +: 4] = pressed;
      frame_done                   = (row_q == 2'd3);
    end

    // A frame is only trusted once it has repeated DEBOUNCE_SCANS times in a row.
    if (frame_done) begin
      prev_frame_d = full_frame;
      if (full_frame == prev_frame_q)
        stable_d = (stable_q >= STB_MAX) ? STB_MAX : stable_q + STB_W'(1);
      else
        stable_d = STB_W'(1);

      if (stable_d == STB_MAX) begin
        acc_frame_d = full_frame;
        new_bits    = full_frame & ~acc_frame_q;
        one_hot     = (full_frame != 16'd0) &&
                      ((full_frame & (full_frame - 16'd1)) == 16'd0);
        digit_ok    = one_hot && ((full_frame & new_bits) != 16'd0);
      end
    end

    for (int i = 0; i < 16; i++)
      if (full_frame[i]) digit_code = 4'(i);

    if (digit_ok) begin
      key_strobe_d  = 1'b1;
      key_code_d    = digit_code;
      user_input_d  = {user_input_q[11:0], digit_code};
      digit_count_d = (digit_count_q >= 3'd4) ? 3'd4 : digit_count_q + 3'd1;
    end

    // Discarding the entry wins over a digit landing on the same edge.
    if (clear || consume) begin
      user_input_d  = 16'd0;
      digit_count_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q    <= 4'hF;
      col_sync_q    <= 4'hF;
      scan_cnt_q    <= '0;
      row_q         <= 2'd0;
      frame_q       <= 16'd0;
      prev_frame_q  <= 16'd0;
      stable_q      <= '0;
      acc_frame_q   <= 16'd0;
      user_input_q  <= 16'd0;
      digit_count_q <= 3'd0;
      key_strobe_q  <= 1'b0;
      key_code_q    <= 4'd0;
    end else begin
      col_meta_q    <= col_meta_d;
      col_sync_q    <= col_sync_d;
      scan_cnt_q    <= scan_cnt_d;
      row_q         <= row_d;
      frame_q       <= frame_d;
      prev_frame_q  <= prev_frame_d;
      stable_q      <= stable_d;
      acc_frame_q   <= acc_frame_d;
      user_input_q  <= user_input_d;
      digit_count_q <= digit_count_d;
      key_strobe_q  <= key_strobe_d;
      key_code_q    <= key_code_d;
    end
  end

  assign row_n       = ~(4'b0001 << row_q);
  assign user_input  = user_input_q;
  assign digit_count = digit_count_q;
  assign input_valid = (digit_count_q != 3'd0);
  assign key_strobe  = key_strobe_q;
  assign key_code    = key_code_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: keypad matrix model, digit-sequence reference
// model, table-driven entry vectors, corner-case sequences and random presses.
module tb_hex_keypad_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        clear = 1'b0;
  logic        consume = 1'b0;
  logic [15:0] user_input;
  logic        input_valid;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic [3:0]  key_code;

  logic [15:0] keys = 16'd0;
  int          total = 0;
  int          passed = 0;
  int          strobe_cnt = 0;
  int          digits[$];
  int          last_code = 0;

  typedef struct {
    int          key;
    logic [15:0] exp_value;
    int          exp_count;
  } vec_t;
  vec_t vecs[5];

  hex_keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .clear(clear),
    .consume(consume), .user_input(user_input), .input_valid(input_valid),
    .digit_count(digit_count), .key_strobe(key_strobe), .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key shorts its row line onto its column line.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[4*r+c]) col_n[c] = 1'b0;
  end

  always @(posedge clk) begin
    #2;
    if (key_strobe) strobe_cnt++;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [15:0] k, input int frames);
    keys = k;
    repeat (frames * FRAME) @(negedge clk);
  endtask

  task automatic modelDigit(input int k);
    digits.push_back(k);
    if (digits.size() > 4) digits.delete(0);
    last_code = k;
  endtask

  function automatic int unsigned expValue();
    int unsigned v = 0;
    foreach (digits[i]) v = (v << 4) | digits[i];
    return v;
  endfunction

  task automatic checkEntry(input string tag);
    checkOutput({tag, ".user_input"}, user_input, expValue());
    checkOutput({tag, ".digit_count"}, digit_count, digits.size());
    checkOutput({tag, ".input_valid"}, input_valid, (digits.size() != 0) ? 1 : 0);
    checkOutput({tag, ".key_code"}, key_code, last_code);
  endtask

  task automatic pulseDiscard(input logic clr, input logic con);
    clear = clr;
    consume = con;
    @(posedge clk);
    #1;
    clear = 1'b0;
    consume = 1'b0;
    digits.delete();
    checkEntry("discard");
    @(negedge clk);
  endtask

  // One full press/release of a single key, expecting exactly one digit.
  task automatic pressKey(input int k, input string tag);
    int s0;
    s0 = strobe_cnt;
    applyStimulus(16'(1) << k, 4);
    applyStimulus(16'd0, 4);
    modelDigit(k);
    checkOutput({tag, ".strobes"}, strobe_cnt - s0, 1);
    checkEntry(tag);
  endtask

  initial begin
    int s0;
    bit got;

    vecs[0] = '{key: 1,  exp_value: 16'h0001, exp_count: 1};
    vecs[1] = '{key: 2,  exp_value: 16'h0012, exp_count: 2};
    vecs[2] = '{key: 3,  exp_value: 16'h0123, exp_count: 3};
    vecs[3] = '{key: 10, exp_value: 16'h123A, exp_count: 4};
    vecs[4] = '{key: 5,  exp_value: 16'h23A5, exp_count: 4};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.row_n", row_n, 4'b1110);
    checkEntry("reset");
    checkOutput("reset.key_strobe", key_strobe, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("scan.row_n[%0d]", i), row_n, 4'hF & ~(4'b0001 << ((i / SCAN_DIV) % 4)));
      @(negedge clk);
    end

    for (int i = 0; i < 5; i++) begin
      s0 = strobe_cnt;
      applyStimulus(16'(1) << vecs[i].key, 4);
      applyStimulus(16'd0, 4);
      modelDigit(vecs[i].key);
      checkOutput($sformatf("vec%0d.strobes", i), strobe_cnt - s0, 1);
      checkOutput($sformatf("vec%0d.user_input", i), user_input, vecs[i].exp_value);
      checkOutput($sformatf("vec%0d.digit_count", i), digit_count, vecs[i].exp_count);
      checkOutput($sformatf("vec%0d.input_valid", i), input_valid, 1);
      checkOutput($sformatf("vec%0d.key_code", i), key_code, vecs[i].key);
    end
    pulseDiscard(1'b0, 1'b1);

    s0 = strobe_cnt;
    applyStimulus(16'(1) << 7, 20);
    applyStimulus(16'd0, 4);
    modelDigit(7);
    checkOutput("hold7.strobes", strobe_cnt - s0, 1);
    checkEntry("hold7");

    s0 = strobe_cnt;
    applyStimulus((16'(1) << 4) | (16'(1) << 9), 6);
    applyStimulus(16'd0, 4);
    checkOutput("multi.strobes", strobe_cnt - s0, 0);
    checkEntry("multi");

    s0 = strobe_cnt;
    for (int i = 0; i < 5; i++) applyStimulus((i % 2 == 0) ? 16'(1) << 6 : 16'd0, 1);
    checkOutput("bounce.early_strobes", strobe_cnt - s0, 0);
    applyStimulus(16'(1) << 6, 4);
    applyStimulus(16'd0, 4);
    modelDigit(6);
    checkOutput("bounce.strobes", strobe_cnt - s0, 1);
    checkEntry("bounce");

    keys = 16'(1) << 12;
    got = 1'b0;
    for (int i = 0; i < 8 * FRAME && !got; i++) begin
      @(negedge clk);
      got = key_strobe;
    end
    checkOutput("consume_c.strobe_seen", got, 1);
    consume = 1'b1;
    @(posedge clk);
    #1;
    consume = 1'b0;
    digits.delete();
    last_code = 12;
    checkEntry("consume_c");
    @(negedge clk);
    applyStimulus(16'd0, 4);

    pressKey(2, "pre_reset");
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    digits.delete();
    last_code = 0;
    checkOutput("midreset.row_n", row_n, 4'b1110);
    checkOutput("midreset.key_strobe", key_strobe, 0);
    checkEntry("midreset");
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 10; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) pulseDiscard(1'b1, 1'b0);
      else if (sel == 1) pulseDiscard(1'b1, 1'b1);
      else pressKey($urandom_range(0, 15), $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
